// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI master and its clock divider.
package spi_pkg;

    localparam int DATA_WIDTH_DEF    = 16;
    localparam int BIT_CNT_WIDTH_DEF = 4;
    localparam int CLK_DIV_DEF       = 8;

    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_SETUP = 3'd1;
    localparam logic [2:0] ENC_XFER  = 3'd2;
    localparam logic [2:0] ENC_HOLD  = 3'd3;
    localparam logic [2:0] ENC_GAP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = ENC_IDLE,
        ST_SETUP = ENC_SETUP,
        ST_XFER  = ENC_XFER,
        ST_HOLD  = ENC_HOLD,
        ST_GAP   = ENC_GAP
    } state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: down-counter reloaded on accept, parked at zero while idle.
module spi_clk_div #(
    parameter int CLK_DIV = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic run_i,
    output logic tick_o,
    output logic pre_tick_o
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (!run_i) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o     = run_i && (cnt_q == '0);
    // One cycle early, so GAP plus the IDLE accept cycle spans exactly CLK_DIV cycles of ss high.
    assign pre_tick_o = run_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one MSB-first frame per accept, sck idle low, ss active low.
// SPI_MASTER_BURST_EN: a start in the done cycle chains the next frame with ss held low.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int BIT_CNT_WIDTH = BIT_CNT_WIDTH_DEF,
    parameter int CLK_DIV       = CLK_DIV_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  ss,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso
);

    state_e                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic                     sck_q, sck_d, mosi_q, mosi_d;
    logic                     ss_q, ss_d, done_q, done_d;
    logic                     accept, tick, pre_tick, run;

    assign run = (state_q != ST_IDLE);

`ifdef SPI_MASTER_BURST_EN
    assign accept = start && ((state_q == ST_IDLE) || ((state_q == ST_GAP) && done_q));
    // A chained frame must not show a one-cycle ss release in the done cycle.
    assign ss     = ss_q & ~(done_q & start & ~rst);
`else
    assign accept = start && (state_q == ST_IDLE);
    assign ss     = ss_q;
`endif

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (accept),
        .run_i      (run),
        .tick_o     (tick),
        .pre_tick_o (pre_tick)
    );

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        dout_d    = dout_q;
        bit_cnt_d = bit_cnt_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        ss_d      = ss_q;
        done_d    = 1'b0;
        case (state_q)
            ST_SETUP: if (tick) state_d = ST_XFER;
            ST_XFER: begin
                if (tick && !sck_q) begin
                    sck_d     = 1'b1;
                    rx_d      = {rx_q[DATA_WIDTH-2:0], miso};
                    bit_cnt_d = bit_cnt_q + BIT_CNT_WIDTH'(1);
                end else if (tick) begin
                    sck_d = 1'b0;
                    // Counter has wrapped to zero only after the last rising edge.
                    if (bit_cnt_q == '0) begin
                        state_d = ST_HOLD;
                    end else begin
                        tx_d   = tx_q << 1;
                        mosi_d = tx_q[DATA_WIDTH-2];
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    done_d  = 1'b1;
                    dout_d  = rx_q;
                    ss_d    = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: if (pre_tick) state_d = ST_IDLE;
            default: ;
        endcase
        if (accept) begin
            state_d   = ST_SETUP;
            tx_d      = din;
            mosi_d    = din[DATA_WIDTH-1];
            ss_d      = 1'b0;
            sck_d     = 1'b0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            dout_q    <= '0;
            bit_cnt_q <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            ss_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            dout_q    <= dout_d;
            bit_cnt_q <= bit_cnt_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            ss_q      <= ss_d;
            done_q    <= done_d;
        end
    end

    assign busy = run;
    assign done = done_q;
    assign dout = dout_q;
    assign sck  = sck_q;
    assign mosi = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV 8 and 4), each wired to a behavioural mode-0 slave.
module tb_spi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  start_v = '0;
    logic [1:0]  busy_v, done_v, ss_v, sck_v, mosi_v;
    logic [1:0]  miso_v = '0;
    logic [15:0] din_v [2];
    logic [15:0] dout_v [2];

    logic [15:0] sl_din [2];
    logic [15:0] sl_tx [2];
    logic [15:0] sl_rx [2];
    logic [15:0] sl_last [2];
    logic [15:0] sl_prev [2];
    int          sl_cnt [2];
    int          sl_nw [2];
    int          rises [2];
    int          dones [2];
    logic [1:0]  ss_p = '1;
    logic [1:0]  sck_p = '0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master #(.DATA_WIDTH(16), .BIT_CNT_WIDTH(4), .CLK_DIV(8)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .din(din_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .dout(dout_v[0]), .ss(ss_v[0]), .sck(sck_v[0]),
        .mosi(mosi_v[0]), .miso(miso_v[0]));

    spi_master #(.DATA_WIDTH(16), .BIT_CNT_WIDTH(4), .CLK_DIV(4)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .din(din_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .dout(dout_v[1]), .ss(ss_v[1]), .sck(sck_v[1]),
        .mosi(mosi_v[1]), .miso(miso_v[1]));

    // Mode-0 slave: loads its word on ss fall (or after every 16th bit), samples on sck rise.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (done_v[k] === 1'b1) dones[k]++;
            if (ss_v[k] === 1'b1 && ss_p[k] === 1'b0) sl_cnt[k] = 0;
            if (ss_v[k] === 1'b0 && ss_p[k] === 1'b1) begin
                sl_tx[k]  = sl_din[k];
                miso_v[k] = sl_tx[k][15];
                sl_cnt[k] = 0;
            end else if (ss_v[k] === 1'b0) begin
                if (sck_v[k] === 1'b1 && sck_p[k] === 1'b0) begin
                    sl_rx[k] = {sl_rx[k][14:0], mosi_v[k]};
                    sl_cnt[k]++;
                    rises[k]++;
                    if (sl_cnt[k] % 16 == 0) begin
                        sl_prev[k] = sl_last[k];
                        sl_last[k] = sl_rx[k];
                        sl_nw[k]++;
                    end
                end else if (sck_v[k] === 1'b0 && sck_p[k] === 1'b1) begin
                    if (sl_cnt[k] % 16 == 0) sl_tx[k] = sl_din[k];
                    else sl_tx[k] = sl_tx[k] << 1;
                    miso_v[k] = sl_tx[k][15];
                end
            end
            ss_p[k]  = ss_v[k];
            sck_p[k] = sck_v[k];
        end
    end

    task automatic start_frame(input int k, input logic [15:0] mw, input logic [15:0] sw,
                               output int acc);
        sl_din[k] = sw;
        @(negedge clk);
        din_v[k]   = mw;
        start_v[k] = 1'b1;
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_done(input int k, input int budget, output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done_v[k] === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int k);
        for (int i = 0; i < 100; i++) begin
            if (busy_v[k] === 1'b0) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        start_v[0] = 1'b1;
        din_v[0]   = 16'hFFFF;
        din_v[1]   = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (ss_v[0] !== 1'b1) begin n_err++; $display("FAIL reset_ss: got %b want 1", ss_v[0]); end
        n_vec++; if (sck_v[0] !== 1'b0) begin n_err++; $display("FAIL reset_sck: got %b want 0", sck_v[0]); end
        n_vec++; if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_v[0]); end
        n_vec++; if (done_v[0] !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_v[0]); end
        n_vec++; if (dout_v[0] !== 16'h0000) begin n_err++; $display("FAIL reset_dout: got %h want 0000", dout_v[0]); end
        n_vec++; if (ss_v[1] !== 1'b1 || busy_v[1] !== 1'b0) begin
            n_err++; $display("FAIL reset_div4: got ss=%b busy=%b want ss=1 busy=0", ss_v[1], busy_v[1]);
        end
        start_v[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_vec++; if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL reset_start_ignored: busy %b want 0", busy_v[0]); end
    endtask

    task automatic test_loopback();
        int acc, at, r0, d0;
        bit ok;
        r0 = rises[0];
        d0 = dones[0];
        start_frame(0, 16'hA5C3, 16'h5555, acc);
        wait_done(0, 400, at, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL loop_done_timeout: no done within 400 cycles"); end
        n_vec++; if (at - acc !== 272) begin n_err++; $display("FAIL loop_latency: got %0d want 272", at - acc); end
        n_vec++; if (dout_v[0] !== 16'h5555) begin n_err++; $display("FAIL loop_mdout: got %h want 5555", dout_v[0]); end
        n_vec++; if (ss_v[0] !== 1'b1) begin n_err++; $display("FAIL loop_ss_at_done: got %b want 1", ss_v[0]); end
        n_vec++; if (sl_last[0] !== 16'hA5C3) begin n_err++; $display("FAIL loop_sdout: got %h want a5c3", sl_last[0]); end
        wait_idle(0);
        n_vec++; if (rises[0] - r0 !== 16) begin n_err++; $display("FAIL loop_rises: got %0d want 16", rises[0] - r0); end
        n_vec++; if (dones[0] - d0 !== 1) begin n_err++; $display("FAIL loop_done_count: got %0d want 1", dones[0] - d0); end
        n_vec++; if (busy_v[0] !== 1'b0 || sck_v[0] !== 1'b0) begin
            n_err++; $display("FAIL loop_idle: got busy=%b sck=%b want 0 0", busy_v[0], sck_v[0]);
        end
    endtask

    task automatic test_lockout();
        int acc, at, d0;
        bit ok;
        logic [15:0] sw;
        sw = 16'($urandom);
        d0 = dones[0];
        start_frame(0, 16'h1234, sw, acc);
        repeat (49) @(posedge clk);
        @(negedge clk);
        din_v[0]   = 16'hFFFF;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        wait_done(0, 400, at, ok);
        n_vec++; if (!ok || at - acc !== 272) begin
            n_err++; $display("FAIL lock_latency: got ok=%0d lat=%0d want 272", ok, at - acc);
        end
        n_vec++; if (sl_last[0] !== 16'h1234) begin n_err++; $display("FAIL lock_sdout: got %h want 1234", sl_last[0]); end
        n_vec++; if (dout_v[0] !== sw) begin n_err++; $display("FAIL lock_mdout: got %h want %h", dout_v[0], sw); end
        wait_idle(0);
        repeat (20) @(posedge clk);
        #1;
        n_vec++; if (dones[0] - d0 !== 1) begin n_err++; $display("FAIL lock_done_count: got %0d want 1", dones[0] - d0); end
        n_vec++; if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL lock_no_restart: busy %b want 0", busy_v[0]); end
    endtask

    task automatic test_reset_mid();
        int acc, at, r0, d0;
        bit ok, seen;
        logic [15:0] sw;
        r0 = rises[0];
        start_frame(0, 16'($urandom), 16'($urandom), acc);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rises[0] - r0 == 7) begin seen = 1'b1; break; end
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL mid_7th_rise_timeout: rises=%0d want 7", rises[0] - r0); end
        d0  = dones[0];
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (ss_v[0] !== 1'b1 || sck_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_outputs: got ss=%b sck=%b busy=%b want 1 0 0", ss_v[0], sck_v[0], busy_v[0]);
        end
        n_vec++; if (done_v[0] !== 1'b0 || dout_v[0] !== 16'h0 || mosi_v[0] !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_data: got done=%b dout=%h mosi=%b want 0 0000 0", done_v[0], dout_v[0], mosi_v[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        n_vec++; if (dones[0] - d0 !== 0) begin n_err++; $display("FAIL mid_no_done: got %0d done pulses want 0", dones[0] - d0); end
        sw = 16'($urandom);
        start_frame(0, 16'h0F0F, sw, acc);
        wait_done(0, 400, at, ok);
        n_vec++; if (!ok || sl_last[0] !== 16'h0F0F) begin
            n_err++; $display("FAIL mid_next_frame: got ok=%0d sdout=%h want 0f0f", ok, sl_last[0]);
        end
        n_vec++; if (dout_v[0] !== sw) begin n_err++; $display("FAIL mid_next_mdout: got %h want %h", dout_v[0], sw); end
        wait_idle(0);
    endtask

    task automatic test_back_to_back();
        int acc, at1, at2, d0, ss_hi, exp_hi;
        bit ok1, ok2;
        logic [15:0] sw1, sw2, dout1;
`ifdef SPI_MASTER_BURST_EN
        exp_hi = 0;
`else
        exp_hi = 8;
`endif
        sw1 = 16'($urandom);
        sw2 = 16'($urandom);
        d0  = dones[0];
        start_frame(0, 16'h0001, sw1, acc);
        @(negedge clk);
        #1;
        sl_din[0] = sw2;
        wait_done(0, 400, at1, ok1);
        dout1      = dout_v[0];
        din_v[0]   = 16'h8000;
        start_v[0] = 1'b1;
        #1;
        ss_hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (ss_v[0] === 1'b0) break;
            ss_hi++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        wait_done(0, 400, at2, ok2);
        n_vec++; if (!ok1 || !ok2) begin n_err++; $display("FAIL b2b_done_timeout: got ok1=%0d ok2=%0d want 1 1", ok1, ok2); end
        n_vec++; if (ss_hi !== exp_hi) begin n_err++; $display("FAIL b2b_ss_gap: got %0d cycles want %0d", ss_hi, exp_hi); end
        n_vec++; if (at2 - at1 !== 272 + ((exp_hi == 0) ? 1 : exp_hi)) begin
            n_err++; $display("FAIL b2b_spacing: got %0d want %0d", at2 - at1, 272 + ((exp_hi == 0) ? 1 : exp_hi));
        end
        n_vec++; if (sl_prev[0] !== 16'h0001 || sl_last[0] !== 16'h8000) begin
            n_err++; $display("FAIL b2b_sdout: got %h,%h want 0001,8000", sl_prev[0], sl_last[0]);
        end
        n_vec++; if (dout1 !== sw1 || dout_v[0] !== sw2) begin
            n_err++; $display("FAIL b2b_mdout: got %h,%h want %h,%h", dout1, dout_v[0], sw1, sw2);
        end
        wait_idle(0);
        n_vec++; if (dones[0] - d0 !== 2) begin n_err++; $display("FAIL b2b_done_count: got %0d want 2", dones[0] - d0); end
    endtask

    task automatic test_min_div();
        int acc, at, r0;
        bit ok;
        r0 = rises[1];
        start_frame(1, 16'hFFFF, 16'h0000, acc);
        wait_done(1, 300, at, ok);
        n_vec++; if (!ok || at - acc !== 136) begin n_err++; $display("FAIL div4_latency: got ok=%0d lat=%0d want 136", ok, at - acc); end
        n_vec++; if (sl_last[1] !== 16'hFFFF) begin n_err++; $display("FAIL div4_sdout: got %h want ffff", sl_last[1]); end
        n_vec++; if (dout_v[1] !== 16'h0000) begin n_err++; $display("FAIL div4_mdout: got %h want 0000", dout_v[1]); end
        wait_idle(1);
        n_vec++; if (rises[1] - r0 !== 16) begin n_err++; $display("FAIL div4_rises: got %0d want 16", rises[1] - r0); end
    endtask

    task automatic test_random();
        int acc, at, k, lat;
        bit ok;
        logic [15:0] mw, sw;
        for (int i = 0; i < 8; i++) begin
            k   = i % 2;
            mw  = 16'($urandom);
            sw  = 16'($urandom);
            lat = ((k == 0) ? 8 : 4) * (2 * 16 + 2);
            start_frame(k, mw, sw, acc);
            wait_done(k, 400, at, ok);
            n_vec++; if (!ok || at - acc !== lat) begin
                n_err++; $display("FAIL rand_latency[%0d]: got ok=%0d lat=%0d want %0d", i, ok, at - acc, lat);
            end
            n_vec++; if (sl_last[k] !== mw) begin n_err++; $display("FAIL rand_sdout[%0d]: got %h want %h", i, sl_last[k], mw); end
            n_vec++; if (dout_v[k] !== sw) begin n_err++; $display("FAIL rand_mdout[%0d]: got %h want %h", i, dout_v[k], sw); end
            wait_idle(k);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_lockout();
        test_reset_mid();
        test_back_to_back();
        test_min_div();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
